// File: rtl/gate_sweep_checker.sv
// Gate-set sweep checker: drives A/B through the four input vectors, waits SETTLE
// cycles per vector, then compares the six gate outputs against their Boolean functions.
//
// state | meaning
// IDLE  | after reset; A=B=0, waiting for start
// WAIT  | vector idx is driven; settle counter runs 0..SETTLE-1, compare on its last value
// DONE  | sweep finished; done/pass/results held until start or rst
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       notA,
  input  logic       AandB,
  input  logic       AorB,
  input  logic       AnorB,
  input  logic       AnandB,
  input  logic       AexorB,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [5:0] fail_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  localparam logic [3:0] lastCnt = 4'(SETTLE - 1);

  stateT      state;
  logic [1:0] idx;
  logic [1:0] nextIdx;
  logic [3:0] settleCnt;
  logic [5:0] expGates;
  logic [5:0] obsGates;
  logic [5:0] gateMiss;
  logic       anyMiss;

  assign nextIdx = idx + 2'd1;

  // Case inequality so an X or Z on a gate output is flagged rather than absorbed.
  always_comb begin
    expGates = {A ^ B, ~(A & B), ~(A | B), A | B, A & B, ~A};
    obsGates = {AexorB, AnandB, AnorB, AorB, AandB, notA};
    for (int g = 0; g < 6; g++) begin
      gateMiss[g] = (obsGates[g] !== expGates[g]);
    end
    anyMiss = |gateMiss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      settleCnt <= 4'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 6'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WAIT;
            idx       <= 2'd0;
            settleCnt <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 6'd0;
            fail_vec  <= 4'd0;
          end
        end
        WAIT: begin
          if (settleCnt == lastCnt) begin
            fail_mask     <= fail_mask | gateMiss;
            fail_vec[idx] <= anyMiss;
            err_count     <= err_count + {2'b00, anyMiss};
            if (idx == 2'd3) begin
              state <= DONE;
              A     <= 1'b0;
              B     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Folds in the last vector's result, which err_count has not seen yet.
              pass  <= (err_count == 3'd0) && !anyMiss;
            end else begin
              idx       <= nextIdx;
              A         <= nextIdx[0];
              B         <= nextIdx[1];
              settleCnt <= 4'd0;
            end
          end else begin
            settleCnt <= settleCnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (SETTLE=2 and SETTLE=1) driven by a gate
// model with per-vector fault tables; expected results come from the fault tables alone.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       startS[2];
  logic       aS[2], bS[2], busyS[2], doneS[2], passS[2];
  logic [2:0] errS[2];
  logic [5:0] maskS[2];
  logic [3:0] vecS[2];
  logic [5:0] gIn[2];
  logic [5:0] ft[2][4];
  int         nChecks = 0;
  int         nErrors = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] goodGates(input logic a, input logic b);
    return {a ^ b, ~(a & b), ~(a | b), a | b, a & b, ~a};
  endfunction

  // Faulty gates: the correct output flipped wherever the table for the current vector says.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      gIn[d] = goodGates(aS[d], bS[d]) ^ ft[d][{bS[d], aS[d]}];
    end
  end

  gate_sweep_checker #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(startS[0]), .A(aS[0]), .B(bS[0]),
    .notA(gIn[0][0]), .AandB(gIn[0][1]), .AorB(gIn[0][2]), .AnorB(gIn[0][3]),
    .AnandB(gIn[0][4]), .AexorB(gIn[0][5]),
    .busy(busyS[0]), .done(doneS[0]), .pass(passS[0]),
    .err_count(errS[0]), .fail_mask(maskS[0]), .fail_vec(vecS[0])
  );

  gate_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(startS[1]), .A(aS[1]), .B(bS[1]),
    .notA(gIn[1][0]), .AandB(gIn[1][1]), .AorB(gIn[1][2]), .AnorB(gIn[1][3]),
    .AnandB(gIn[1][4]), .AexorB(gIn[1][5]),
    .busy(busyS[1]), .done(doneS[1]), .pass(passS[1]),
    .err_count(errS[1]), .fail_mask(maskS[1]), .fail_vec(vecS[1])
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setFaults(input int d, input logic [5:0] f0, input logic [5:0] f1,
                           input logic [5:0] f2, input logic [5:0] f3);
    ft[d][0] = f0;
    ft[d][1] = f1;
    ft[d][2] = f2;
    ft[d][3] = f3;
  endtask

  task automatic checkZero(input int d, input string tag);
    checkVal({tag, " A"}, aS[d], 0);
    checkVal({tag, " B"}, bS[d], 0);
    checkVal({tag, " busy"}, busyS[d], 0);
    checkVal({tag, " done"}, doneS[d], 0);
    checkVal({tag, " pass"}, passS[d], 0);
    checkVal({tag, " err"}, errS[d], 0);
    checkVal({tag, " mask"}, maskS[d], 0);
    checkVal({tag, " vec"}, vecS[d], 0);
  endtask

  // State k cycles after the accepting edge: vector k/SETTLE is driven, k/SETTLE vectors
  // have been sampled, and their results follow directly from the fault table.
  task automatic checkStep(input int d, input string tag, input int k);
    int         s;
    int         nSamp;
    int         e;
    logic [5:0] m;
    logic [3:0] v;
    string      t;
    s     = (d == 0) ? 2 : 1;
    nSamp = k / s;
    e     = 0;
    m     = '0;
    v     = '0;
    t     = $sformatf("%s s%0d k%0d", tag, s, k);
    for (int i = 0; i < nSamp; i++) begin
      m = m | ft[d][i];
      if (ft[d][i] != 6'd0) begin
        v[i] = 1'b1;
        e++;
      end
    end
    if (nSamp < 4) begin
      checkVal({t, " A"}, aS[d], nSamp & 1);
      checkVal({t, " B"}, bS[d], (nSamp >> 1) & 1);
      checkVal({t, " busy"}, busyS[d], 1);
      checkVal({t, " done"}, doneS[d], 0);
    end else begin
      checkVal({t, " A"}, aS[d], 0);
      checkVal({t, " B"}, bS[d], 0);
      checkVal({t, " busy"}, busyS[d], 0);
      checkVal({t, " done"}, doneS[d], 1);
      checkVal({t, " pass"}, passS[d], (e == 0) ? 1 : 0);
    end
    checkVal({t, " err"}, errS[d], e);
    checkVal({t, " mask"}, maskS[d], m);
    checkVal({t, " vec"}, vecS[d], v);
  endtask

  task automatic runSweep(input int d, input string tag, input bit keepStart,
                          input bit preStarted);
    int s;
    s = (d == 0) ? 2 : 1;
    if (!preStarted) begin
      @(negedge clk);
      startS[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (!keepStart) startS[d] = 1'b0;
    checkStep(d, tag, 0);
    for (int k = 1; k <= 4 * s; k++) begin
      @(negedge clk);
      checkStep(d, tag, k);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) setFaults(d, 6'd0, 6'd0, 6'd0, 6'd0);
    rst       = 1'b1;
    startS[0] = 1'b1;
    startS[1] = 1'b1;
    repeat (3) @(negedge clk);
    checkZero(0, "reset2");
    checkZero(1, "reset1");
    rst       = 1'b0;
    startS[0] = 1'b0;
    startS[1] = 1'b0;

    runSweep(0, "clean", 1'b0, 1'b0);
    checkVal("clean pass", passS[0], 1);
    checkVal("clean mask", maskS[0], 6'h00);

    setFaults(0, 6'd0, 6'd0, 6'd0, 6'b000010);
    runSweep(0, "andStuck0", 1'b0, 1'b0);
    checkVal("andStuck0 err", errS[0], 1);
    checkVal("andStuck0 mask", maskS[0], 6'b000010);
    checkVal("andStuck0 vec", vecS[0], 4'b1000);

    setFaults(0, 6'h20, 6'h20, 6'h20, 6'h20);
    runSweep(0, "xnor", 1'b0, 1'b0);
    checkVal("xnor err", errS[0], 4);
    checkVal("xnor mask", maskS[0], 6'b100000);
    checkVal("xnor vec", vecS[0], 4'b1111);
    checkVal("xnor pass", passS[0], 0);

    // Reset lands on edge T0+5 in the middle of vector 2; start is also high there.
    setFaults(0, 6'd0, 6'd0, 6'd0, 6'd0);
    @(negedge clk);
    startS[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startS[0] = 1'b0;
    checkStep(0, "rstMid", 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkStep(0, "rstMid", k);
    end
    rst       = 1'b1;
    startS[0] = 1'b1;
    @(negedge clk);
    checkZero(0, "rstMid after");
    rst       = 1'b0;
    startS[0] = 1'b0;
    @(negedge clk);
    checkZero(0, "rstMid idle");
    runSweep(0, "afterRst", 1'b0, 1'b0);

    // Start held through a sweep, then accepted again on the first DONE edge.
    runSweep(0, "heldA", 1'b1, 1'b0);
    runSweep(0, "heldB", 1'b0, 1'b1);

    runSweep(1, "settle1", 1'b0, 1'b0);
    checkVal("settle1 pass", passS[1], 1);

    for (int r = 0; r < 10; r++) begin
      int d;
      d = $urandom_range(0, 1);
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        setFaults(d, 6'd0, 6'd0, 6'd0, 6'd0);
      end else begin
        for (int i = 0; i < 4; i++) begin
          ft[d][i] = 6'($urandom) & 6'($urandom) & 6'($urandom);
        end
      end
      runSweep(d, $sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
